// File: rtl/jacaranda_mem_arbiter_if.sv
// rtl/jacaranda_mem_arbiter_if.sv - signal bundle for the jacaranda-8 SRAM arbiter
// Purpose : groups the Wishbone slave port, the core memory port and the SRAM
//           port of jacaranda_mem_arbiter into one interface.
// Modports: slave  - arbiter view (Wishbone/core/SRAM-read in, responses out)
//           master - surrounding system view (SoC, core and SRAM model)
// Signals : wbs_* Wishbone classic slave, cpu_* core fetch/load port,
//           mem_* single-port synchronous SRAM port.
interface jacaranda_mem_arbiter_if #(
   parameter int AW = 8
);
   logic          wbs_cyc_i;
   logic          wbs_stb_i;
   logic          wbs_we_i;
   logic [3:0]    wbs_sel_i;
   logic [31:0]   wbs_adr_i;
   logic [31:0]   wbs_dat_i;
   logic [31:0]   wbs_dat_o;
   logic          wbs_ack_o;

   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_rvalid;
   logic [7:0]    cpu_rdata;
   logic          cpu_rst_n;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  mem_rdata,
      output wbs_dat_o, wbs_ack_o,
      output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_rst_n,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output mem_rdata,
      input  wbs_dat_o, wbs_ack_o,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_rst_n,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/jacaranda_mem_arbiter.sv
// rtl/jacaranda_mem_arbiter.sv - SRAM arbiter and run control for the jacaranda-8 core
// Purpose : shares one single-port SRAM between the Wishbone slave port and the
//           jacaranda-8 core, holds the core in reset until CTRL.run is set,
//           and counts core stall cycles.
// Ports   : clock  - system clock
//           resetb - asynchronous active-low reset
//           bus    - jacaranda_mem_arbiter_if.slave (Wishbone, core, SRAM)
module jacaranda_mem_arbiter #(
   parameter logic [31:0] BASE_ADR     = 32'h3000_0000,
   parameter int          AW           = 8,
   parameter int          STARVE_LIMIT = 4
) (
   input  logic                         clock,
   input  logic                         resetb,
   jacaranda_mem_arbiter_if.slave       bus
);
   localparam int WW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WB_MEM = 2'd1,
      WB_ACK = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          run_q, run_d;
   logic [15:0]   stall_q, stall_d;
   logic [WW-1:0] wb_wait_q, wb_wait_d;
   logic [31:0]   dat_q, dat_d;
   logic          rvalid_q, rvalid_d;
   logic          rst_n_q;
   logic          live_q;

   logic          wb_req;
   logic          in_win;
   logic [11:0]   off;
   logic          is_mem, is_ctrl, is_status;
   logic          wb_mem_pend, wb_force, wb_gnt, cpu_gnt_w, status_wr;
   logic          unused_bits;

   // live_q keeps the SRAM port quiet while reset is asserted even if the
   // SoC still holds stb; the arbiter only starts granting after release.
   assign wb_req      = live_q & bus.wbs_cyc_i & bus.wbs_stb_i;
   assign in_win      = (bus.wbs_adr_i[31:12] == BASE_ADR[31:12]);
   assign off         = bus.wbs_adr_i[11:0];
   assign is_mem      = (off[11:10] == 2'b00);
   assign is_ctrl     = (off[11:2] == 10'h100);
   assign is_status   = (off[11:2] == 10'h101);

   // A Wishbone memory access competes for the slot only while waiting in IDLE.
   assign wb_mem_pend = (state_q == IDLE) & wb_req & in_win & is_mem;
   assign wb_force    = (wb_wait_q == WW'(STARVE_LIMIT));
   assign wb_gnt      = wb_mem_pend & (~run_q | ~bus.cpu_req | wb_force);
   assign cpu_gnt_w   = run_q & bus.cpu_req & ~wb_gnt;
   assign status_wr   = (state_q == IDLE) & wb_req & in_win & is_status & bus.wbs_we_i;

   assign unused_bits = &{1'b0, bus.wbs_sel_i[3:1], bus.wbs_dat_i[31:8], bus.wbs_adr_i[1:0]};

   assign bus.cpu_gnt    = cpu_gnt_w;
   // Gating with run_q drops a read whose grant coincided with a run=0 write.
   assign bus.cpu_rvalid = rvalid_q & run_q;
   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.cpu_rst_n  = rst_n_q;
   assign bus.wbs_dat_o  = dat_q;
   // Ack is withheld if the master abandons the cycle in the ack state.
   assign bus.wbs_ack_o  = (state_q == WB_ACK) & wb_req;

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (wb_gnt) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.wbs_we_i & bus.wbs_sel_i[0];
         bus.mem_addr  = bus.wbs_adr_i[AW+1:2];
         bus.mem_wdata = bus.wbs_dat_i[7:0];
      end else if (cpu_gnt_w) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.cpu_we;
         bus.mem_addr  = bus.cpu_addr;
         bus.mem_wdata = bus.cpu_wdata;
      end
   end

   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      dat_d     = dat_q;
      wb_wait_d = wb_wait_q;
      stall_d   = stall_q;
      rvalid_d  = cpu_gnt_w & ~bus.cpu_we;

      case (state_q)
         IDLE: begin
            if (wb_req && in_win) begin
               if (is_mem) begin
                  if (wb_gnt) begin
                     state_d   = WB_MEM;
                     wb_wait_d = '0;
                  end else begin
                     wb_wait_d = wb_wait_q + WW'(1);
                  end
               end else begin
                  // Register accesses never touch the SRAM slot.
                  state_d = WB_ACK;
                  dat_d   = '0;
                  if (bus.wbs_we_i) begin
                     if (is_ctrl) run_d = bus.wbs_dat_i[0];
                  end else if (is_ctrl) begin
                     dat_d = {31'b0, run_q};
                  end else if (is_status) begin
                     dat_d = {stall_q, 15'b0, run_q};
                  end
               end
            end else begin
               wb_wait_d = '0;
            end
         end
         WB_MEM: begin
            // SRAM output is valid here; a started write has already landed.
            if (wb_req) begin
               state_d = WB_ACK;
               dat_d   = bus.wbs_we_i ? 32'b0 : {24'b0, bus.mem_rdata};
            end else begin
               state_d = IDLE;
            end
         end
         WB_ACK:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (status_wr) begin
         stall_d = '0;
      end else if (run_q && bus.cpu_req && !cpu_gnt_w && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q   <= IDLE;
         run_q     <= 1'b0;
         stall_q   <= '0;
         wb_wait_q <= '0;
         dat_q     <= '0;
         rvalid_q  <= 1'b0;
         rst_n_q   <= 1'b0;
         live_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         stall_q   <= stall_d;
         wb_wait_q <= wb_wait_d;
         dat_q     <= dat_d;
         rvalid_q  <= rvalid_d;
         rst_n_q   <= run_q;
         live_q    <= 1'b1;
      end
   end
endmodule

// File: tb/tb_jacaranda_mem_arbiter.sv
// tb/tb_jacaranda_mem_arbiter.sv - scoreboard testbench for jacaranda_mem_arbiter
module tb_jacaranda_mem_arbiter;
   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam int          AW    = 8;
   localparam int          LIMIT = 4;

   logic clock  = 1'b0;
   logic resetb = 1'b1;
   always #5 clock = ~clock;

   jacaranda_mem_arbiter_if #(.AW(AW)) bus ();

   jacaranda_mem_arbiter #(.BASE_ADR(BASE), .AW(AW), .STARVE_LIMIT(LIMIT)) dut (
      .clock (clock),
      .resetb(resetb),
      .bus   (bus)
   );

   // SRAM model: synchronous, read data the cycle after enable.
   logic [7:0] sram [256];
   always @(posedge clock) begin
      if (bus.mem_en) begin
         if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
         bus.mem_rdata <= sram[bus.mem_addr];
      end
   end

   typedef struct {
      bit          is_read;
      logic [31:0] data;
   } wb_exp_t;

   wb_exp_t     wb_q[$];
   logic [7:0]  cpu_q[$];
   logic [7:0]  ref_mem [256];
   bit          model_run = 0;
   bit          watch_gnt = 0;
   bit          suppress  = 0;
   bit          last_gnt  = 0;
   bit          wb_done   = 0;
   logic        ack_rst_n;
   int          checks = 0;
   int          errors = 0;
   wb_exp_t     mon_e;
   logic [7:0]  mon_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check1({tag, "_ack"},     bus.wbs_ack_o,  1'b0);
      check ({tag, "_dat_o"},   bus.wbs_dat_o,  32'h0);
      check1({tag, "_gnt"},     bus.cpu_gnt,    1'b0);
      check1({tag, "_rvalid"},  bus.cpu_rvalid, 1'b0);
      check1({tag, "_rst_n"},   bus.cpu_rst_n,  1'b0);
      check1({tag, "_mem_en"},  bus.mem_en,     1'b0);
      check1({tag, "_mem_we"},  bus.mem_we,     1'b0);
      check ({tag, "_mem_addr"}, {24'h0, bus.mem_addr},  32'h0);
      check ({tag, "_mem_wdata"}, {24'h0, bus.mem_wdata}, 32'h0);
   endtask

   // Issue one Wishbone access; the expected response goes to the scoreboard.
   task automatic wb_access(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                            input logic [31:0] dat, input logic [31:0] exp_rd,
                            input int lat_lo, input int lat_hi);
      int      lat;
      wb_exp_t e;
      @(posedge clock); #1;
      e.is_read = !we;
      e.data    = exp_rd;
      wb_q.push_back(e);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_sel_i = sel;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = dat;
      lat = 0;
      forever begin
         @(negedge clock);
         if (bus.wbs_ack_o) break;
         lat++;
         if (lat > 40) break;
      end
      ack_rst_n = bus.cpu_rst_n;
      check_range("wb_latency", lat, lat_lo, lat_hi);
      if (lat > 40) void'(wb_q.pop_back());
      @(posedge clock); #1;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
   endtask

   task automatic mem_write(input int idx, input logic [7:0] d, input bit sel0, input int lo, input int hi);
      wb_access(BASE + 32'(idx * 4), 1'b1, {3'b0, sel0}, {24'h0, d}, 32'h0, lo, hi);
      if (sel0) ref_mem[idx] = d;
   endtask

   task automatic mem_read(input int idx, input int lo, input int hi);
      wb_access(BASE + 32'(idx * 4), 1'b0, 4'hF, 32'h0, {24'h0, ref_mem[idx]}, lo, hi);
   endtask

   task automatic wb_noack(input logic [31:0] adr);
      int seen = 0;
      @(posedge clock); #1;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_adr_i = adr;
      repeat (10) begin
         @(negedge clock);
         if (bus.wbs_ack_o) seen++;
      end
      check_range("no_ack_outside_window", seen, 0, 0);
      @(posedge clock); #1;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
   endtask

   // Scoreboard monitor: pops expectations whenever the DUT responds.
   always @(negedge clock) begin
      if (bus.wbs_ack_o) begin
         if (wb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected_ack: actual=1 required=0");
         end else begin
            mon_e = wb_q.pop_front();
            if (mon_e.is_read) check("wb_rdata", bus.wbs_dat_o, mon_e.data);
         end
      end
      if (bus.cpu_rvalid) begin
         if (cpu_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL cpu_unexpected_rvalid: actual=1 required=0");
         end else begin
            mon_b = cpu_q.pop_front();
            check("cpu_rdata", {24'h0, bus.cpu_rdata}, {24'h0, mon_b});
         end
      end
      if (watch_gnt) check1("cpu_gnt_while_stopped", bus.cpu_gnt, 1'b0);
      if (bus.cpu_gnt) begin
         if (!model_run) begin
            checks++; errors++;
            $display("FAIL cpu_gnt_run0: actual=1 required=0");
         end
         if (bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
         else if (!suppress) cpu_q.push_back(ref_mem[bus.cpu_addr]);
      end
      last_gnt = bus.cpu_gnt;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         sram[i]    = 8'h00;
         ref_mem[i] = 8'h00;
      end
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
      bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
      #2 resetb = 1'b0;
      repeat (3) @(negedge clock);
      check_reset_outputs("reset");
      @(posedge clock); #1 resetb = 1'b1;
      repeat (2) @(posedge clock);

      // Program load with run=0: core requests are ignored.
      #1;
      bus.cpu_req = 1'b1; bus.cpu_addr = 8'h00; watch_gnt = 1;
      mem_write(0, 8'hA5, 1'b1, 2, 2);
      mem_write(255, 8'h3C, 1'b1, 2, 2);
      mem_read(0, 2, 2);
      mem_read(255, 2, 2);
      watch_gnt = 0; bus.cpu_req = 1'b0;

      // Run control.
      wb_access(BASE + 32'h400, 1'b1, 4'hF, 32'h1, 32'h0, 1, 1);
      model_run = 1;
      check1("cpu_rst_n_at_ack", ack_rst_n, 1'b0);
      @(negedge clock);
      check1("cpu_rst_n_after_ack", bus.cpu_rst_n, 1'b1);
      @(posedge clock); #1;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h00;
      @(negedge clock);
      check1("cpu_gnt_same_cycle", bus.cpu_gnt, 1'b1);
      @(posedge clock); #1;
      bus.cpu_req = 1'b0;
      @(negedge clock);
      check1("cpu_rvalid_next_cycle", bus.cpu_rvalid, 1'b1);

      // Starvation: core requests every cycle.
      @(posedge clock); #1;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h00;
      wb_access(BASE + 32'h404, 1'b1, 4'hF, 32'h0, 32'h0, 1, 1);
      mem_read(1, LIMIT + 2, LIMIT + 2);
      wb_access(BASE + 32'h404, 1'b0, 4'hF, 32'h0, 32'h0001_0001, 1, 1);
      bus.cpu_req = 1'b0;

      // Register map.
      wb_access(BASE + 32'h404, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0, 1, 1);
      wb_access(BASE + 32'h404, 1'b0, 4'hF, 32'h0, 32'h0000_0001, 1, 1);
      wb_access(BASE + 32'h400, 1'b0, 4'hF, 32'h0, 32'h0000_0001, 1, 1);
      wb_access(BASE + 32'h500, 1'b0, 4'hF, 32'h0, 32'h0000_0000, 1, 1);
      wb_noack(32'h3000_1000);

      // Byte-select 0 clear: the write slot is used but the SRAM keeps its value.
      mem_write(2, 8'h5A, 1'b1, 2, 2);
      mem_write(2, 8'hFF, 1'b0, 2, 2);
      mem_read(2, 2, 2);

      // Randomized concurrent traffic: core owns entries 128..255, Wishbone 0..127.
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               int idx = $urandom_range(0, 127);
               if ($urandom_range(0, 1) == 1)
                  mem_write(idx, 8'($urandom), ($urandom_range(0, 3) != 0), 2, LIMIT + 2);
               else
                  mem_read(idx, 2, LIMIT + 2);
            end
            wb_done = 1;
         end
         begin
            while (!wb_done) begin
               @(posedge clock); #1;
               if (!bus.cpu_req || last_gnt) begin
                  bus.cpu_req   = ($urandom_range(0, 3) != 0);
                  bus.cpu_we    = 1'($urandom_range(0, 1));
                  bus.cpu_addr  = 8'(128 + $urandom_range(0, 127));
                  bus.cpu_wdata = 8'($urandom);
               end
            end
            @(posedge clock); #1;
            bus.cpu_req = 1'b0;
         end
      join
      repeat (2) @(negedge clock);

      // Stopping the core drops a read granted in the same cycle.
      suppress = 1;
      fork
         begin
            @(posedge clock); #1;
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h80;
            @(negedge clock);
            check1("suppress_gnt", bus.cpu_gnt, 1'b1);
            @(posedge clock); #1;
            bus.cpu_req = 1'b0;
            @(negedge clock);
            check1("suppress_rvalid", bus.cpu_rvalid, 1'b0);
         end
         wb_access(BASE + 32'h400, 1'b1, 4'hF, 32'h0, 32'h0, 1, 1);
      join
      model_run = 0;
      suppress  = 0;
      @(negedge clock);
      check1("cpu_rst_n_stopped", bus.cpu_rst_n, 1'b0);

      // Reset in the middle of a memory write.
      @(posedge clock); #1;
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
      bus.wbs_sel_i = 4'h1; bus.wbs_adr_i = BASE + 32'h010; bus.wbs_dat_i = 32'h77;
      @(negedge clock);
      check1("abort_grant", bus.mem_en, 1'b1);
      ref_mem[4] = 8'h77;
      @(posedge clock); #2;
      resetb = 1'b0;
      @(negedge clock);
      check_reset_outputs("abort");
      @(negedge clock);
      check1("abort_no_ack", bus.wbs_ack_o, 1'b0);
      @(posedge clock); #1;
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      resetb = 1'b1;
      repeat (2) @(negedge clock);
      check1("post_reset_rst_n", bus.cpu_rst_n, 1'b0);
      wb_access(BASE + 32'h400, 1'b0, 4'hF, 32'h0, 32'h0, 1, 1);
      mem_read(4, 2, 2);

      repeat (3) @(negedge clock);
      check_range("wb_queue_drained", wb_q.size(), 0, 0);
      check_range("cpu_queue_drained", cpu_q.size(), 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
